// File: rtl/ex_int_sequencer.sv
// Interrupt entry/return micro-op sequencer beside the decode/execute boundary.
// Optional nesting (2-bit depth, up to three levels) is enabled by defining EX_INT_NESTING_EN.
module ex_int_sequencer #(
  parameter int             W         = 16,
  parameter logic [W-1:0]   VEC_ADDR  = W'(16'h0020),
  parameter int             DRAIN_CYC = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         int_req,
  input  logic         rti_req,
  input  logic [W-1:0] pc_next,
  input  logic [2:0]   flags_in,
  input  logic         pipe_ready,
  input  logic         pop_valid,
  input  logic [W-1:0] pop_data,
  output logic         stall,
  output logic         uop_valid,
  output logic [1:0]   uop_kind,
  output logic [W-1:0] uop_data,
  output logic         flags_restore,
  output logic [2:0]   flags_out,
  output logic         int_ack,
  output logic         in_isr
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_PUSH_PC, S_PUSH_FL, S_VECTOR, S_POP_FL, S_POP_PC, S_RESUME
  } state_t;

  localparam logic [1:0] KIND_PUSH = 2'b00;
  localparam logic [1:0] KIND_POP  = 2'b01;
  localparam logic [1:0] KIND_JUMP = 2'b10;

  state_t         state_r;
  logic [2:0]     cnt_r;
  logic [W-1:0]   pc_lat_r;
  logic [2:0]     fl_lat_r;
  logic           issued_r;   // POP accepted by the pipe, now waiting for its data
  logic           int_en_s;
  logic           handoff_s;

  assign handoff_s = uop_valid && pipe_ready;

`ifdef EX_INT_NESTING_EN
  logic [1:0] depth_r;
  assign int_en_s = (depth_r != 2'd3);
`else
  assign int_en_s = !in_isr;
`endif

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= S_IDLE;
      cnt_r         <= 3'd0;
      pc_lat_r      <= '0;
      fl_lat_r      <= 3'd0;
      issued_r      <= 1'b0;
      stall         <= 1'b0;
      uop_valid     <= 1'b0;
      uop_kind      <= 2'b00;
      uop_data      <= '0;
      flags_restore <= 1'b0;
      flags_out     <= 3'd0;
      int_ack       <= 1'b0;
      in_isr        <= 1'b0;
`ifdef EX_INT_NESTING_EN
      depth_r       <= 2'd0;
`endif
    end else begin
      int_ack       <= 1'b0;
      flags_restore <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (rti_req && in_isr) begin
            state_r   <= S_POP_FL;
            stall     <= 1'b1;
            uop_valid <= 1'b1;
            uop_kind  <= KIND_POP;
            uop_data  <= '0;
            issued_r  <= 1'b0;
          end else if (int_req && int_en_s) begin
            state_r  <= S_DRAIN;
            pc_lat_r <= pc_next;
            fl_lat_r <= flags_in;
            int_ack  <= 1'b1;
            cnt_r    <= 3'(DRAIN_CYC);
            stall    <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt_r <= 3'd1) begin
            state_r   <= S_PUSH_PC;
            uop_valid <= 1'b1;
            uop_kind  <= KIND_PUSH;
            uop_data  <= pc_lat_r;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        S_PUSH_PC: begin
          if (handoff_s) begin
            state_r  <= S_PUSH_FL;
            uop_kind <= KIND_PUSH;
            uop_data <= {{(W-3){1'b0}}, fl_lat_r};
          end
        end
        S_PUSH_FL: begin
          if (handoff_s) begin
            state_r  <= S_VECTOR;
            uop_kind <= KIND_JUMP;
            uop_data <= VEC_ADDR;
          end
        end
        S_VECTOR: begin
          if (handoff_s) begin
            state_r   <= S_IDLE;
            uop_valid <= 1'b0;
            stall     <= 1'b0;
            in_isr    <= 1'b1;
`ifdef EX_INT_NESTING_EN
            depth_r   <= depth_r + 2'd1;
`endif
          end
        end
        S_POP_FL: begin
          if (!issued_r) begin
            if (handoff_s) begin
              uop_valid <= 1'b0;
              issued_r  <= 1'b1;
            end
          end else if (pop_valid) begin
            state_r       <= S_POP_PC;
            flags_out     <= pop_data[2:0];
            flags_restore <= 1'b1;
            uop_valid     <= 1'b1;
            uop_kind      <= KIND_POP;
            issued_r      <= 1'b0;
          end
        end
        S_POP_PC: begin
          if (!issued_r) begin
            if (handoff_s) begin
              uop_valid <= 1'b0;
              issued_r  <= 1'b1;
            end
          end else if (pop_valid) begin
            state_r   <= S_RESUME;
            uop_valid <= 1'b1;
            uop_kind  <= KIND_JUMP;
            uop_data  <= pop_data;
            issued_r  <= 1'b0;
          end
        end
        S_RESUME: begin
          if (handoff_s) begin
            state_r   <= S_IDLE;
            uop_valid <= 1'b0;
            stall     <= 1'b0;
`ifdef EX_INT_NESTING_EN
            depth_r   <= depth_r - 2'd1;
            in_isr    <= (depth_r != 2'd1);
`else
            in_isr    <= 1'b0;
`endif
          end
        end
        default: begin
          state_r   <= S_IDLE;
          uop_valid <= 1'b0;
          stall     <= 1'b0;
          issued_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
